fp_to_int: RTL and testbench

- Converts one bfloat16-style floating-point operand (sign, 8-bit exponent, 7-bit mantissa; the same format our fadd pipeline produces) to a W-bit two's-complement signed integer.
- Sits on the output side of the floating-point datapath, feeding integer consumers.
- Uses a valid/ready handshake on both sides and an iterative one-bit-per-cycle shifter driven by a small FSM.
- Rounding is truncation toward zero. Overflow, invalid and inexact are flagged.

---
 rtl/fp_to_int.sv | 169 ++++++++++++++++
 tb/tb_fp_to_int.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fp_to_int.sv
// Converts a sign/exponent/mantissa float operand to a W-bit signed integer,
// truncating toward zero, using a one-bit-per-cycle shifter.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// SHIFT | aligning the significand, one bit per cycle
// FIN   | applying the sign, latching result and inexact
// DONE  | result valid, holding until out_ready
module fp_to_int #(
    parameter int EXP_LEN = 8,
    parameter int MAN_LEN = 7,
    parameter int W       = 32
) (
    input  logic                       clock,
    input  logic                       nreset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [EXP_LEN+MAN_LEN:0]   a,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               result,
    output logic                       overflow,
    output logic                       invalid,
    output logic                       inexact
);
    localparam int N     = 1 + EXP_LEN + MAN_LEN;
    localparam int BIAS  = 2**(EXP_LEN-1) - 1;
    localparam int CNT_W = $clog2(W) + 1;
    localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] SAT_POS = ~SAT_NEG;

    typedef enum logic [1:0] {IDLE, SHIFT, FIN, DONE} state_t;

    state_t             state_q;
    logic [W-1:0]       acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               left_q;
    logic               neg_q;
    logic               sticky_q;
    logic [W-1:0]       result_q;
    logic               overflow_q;
    logic               invalid_q;
    logic               inexact_q;
    logic               out_valid_q;

    logic               sign_a;
    logic [EXP_LEN-1:0] exp_a;
    logic [MAN_LEN-1:0] man_a;
    int                 e_a;

    logic [W-1:0]       acc_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               left_d;
    logic               neg_d;
    logic               sticky_d;
    logic               ovf_d;
    logic               inv_d;
    logic               special_d;

    assign sign_a = a[N-1];
    assign exp_a  = a[N-2:MAN_LEN];
    assign man_a  = a[MAN_LEN-1:0];

    // Special cases preload acc/neg with the final magnitude so FIN applies
    // the sign uniformly; -SAT_NEG wraps back to SAT_NEG in W bits.
    always_comb begin
        e_a       = int'(exp_a) - BIAS;
        acc_d     = {{(W-MAN_LEN-1){1'b0}}, 1'b1, man_a};
        cnt_d     = '0;
        left_d    = 1'b0;
        neg_d     = sign_a;
        sticky_d  = 1'b0;
        ovf_d     = 1'b0;
        inv_d     = 1'b0;
        special_d = 1'b1;
        if (exp_a == '1) begin
            if (man_a != '0) begin
                acc_d = '0;
                neg_d = 1'b0;
                inv_d = 1'b1;
            end else begin
                acc_d = sign_a ? SAT_NEG : SAT_POS;
                ovf_d = 1'b1;
            end
        end else if (exp_a == '0) begin
            acc_d    = '0;
            sticky_d = |man_a;
        end else if (e_a < 0) begin
            acc_d    = '0;
            sticky_d = 1'b1;
        end else if (e_a >= W-1) begin
            acc_d = sign_a ? SAT_NEG : SAT_POS;
            ovf_d = !(sign_a && (e_a == W-1) && (man_a == '0));
        end else begin
            special_d = 1'b0;
            if (e_a >= MAN_LEN) begin
                left_d = 1'b1;
                cnt_d  = CNT_W'(e_a - MAN_LEN);
            end else begin
                cnt_d  = CNT_W'(MAN_LEN - e_a);
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            left_q      <= 1'b0;
            neg_q       <= 1'b0;
            sticky_q    <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            invalid_q   <= 1'b0;
            inexact_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        acc_q      <= acc_d;
                        cnt_q      <= cnt_d;
                        left_q     <= left_d;
                        neg_q      <= neg_d;
                        sticky_q   <= sticky_d;
                        overflow_q <= ovf_d;
                        invalid_q  <= inv_d;
                        inexact_q  <= 1'b0;
                        state_q    <= special_d ? FIN : SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (left_q) begin
                            acc_q <= acc_q << 1;
                        end else begin
                            acc_q    <= acc_q >> 1;
                            sticky_q <= sticky_q | acc_q[0];
                        end
                    end else begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    result_q    <= neg_q ? -acc_q : acc_q;
                    inexact_q   <= sticky_q;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign invalid   = invalid_q;
    assign inexact   = inexact_q;
endmodule

// File: tb/tb_fp_to_int.sv
// Bench for fp_to_int: directed and random operands against a value-based
// reference model, including latency, backpressure and mid-conversion reset.
module tb_fp_to_int;
    logic        clock;
    logic        nreset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        invalid;
    logic        inexact;

    int n_tests = 0;
    int n_fail  = 0;

    fp_to_int #(.EXP_LEN(8), .MAN_LEN(7), .W(32)) dut (
        .clock(clock), .nreset(nreset),
        .in_valid(in_valid), .in_ready(in_ready), .a(a),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .invalid(invalid), .inexact(inexact)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Value-level model: the operand is m * 2^(e-7); truncate, then range-check.
    function automatic void model(input logic [15:0] op, output logic [31:0] r,
                                  output logic ov, output logic inv, output logic inx,
                                  output int lat);
        int     ex  = int'(op[14:7]);
        int     mt  = int'(op[6:0]);
        int     e   = ex - 127;
        bit     neg = op[15];
        longint m   = 128 + mt;
        longint mag;
        longint lim;
        r = 0; ov = 0; inv = 0; inx = 0; lat = 1;
        if (ex == 255) begin
            if (mt != 0) inv = 1;
            else begin ov = 1; r = neg ? 32'h8000_0000 : 32'h7FFF_FFFF; end
        end else if (ex == 0) begin
            inx = (mt != 0);
        end else if (e < 0) begin
            inx = 1;
        end else begin
            if (e > 40) mag = longint'(1) << 48;
            else if (e >= 7) mag = m << (e - 7);
            else begin
                mag = m >> (7 - e);
                inx = (m % (longint'(1) << (7 - e))) != 0;
            end
            lim = neg ? (longint'(1) << 31) : (longint'(1) << 31) - 1;
            if (mag > lim) begin
                ov = 1; inx = 0;
                r = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
                r = neg ? 32'(-mag) : 32'(mag);
            end
            if (e <= 30) lat = ((e >= 7) ? e - 7 : 7 - e) + 2;
        end
    endfunction

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clock); #1;
            lat++;
        end while (!out_valid && lat < 40);
    endtask

    task automatic convert(input logic [15:0] op, input int hold);
        logic [31:0] er;
        logic        eo, ei, ex;
        int          elat, lat;
        model(op, er, eo, ei, ex, elat);
        @(negedge clock);
        check($sformatf("in_ready_idle[%h]", op), 64'(in_ready), 64'd1);
        a = op; in_valid = 1'b1; out_ready = (hold == 0);
        @(posedge clock); #1;
        in_valid = 1'b0; a = 16'($urandom);
        wait_valid(lat);
        check($sformatf("latency[%h]", op), 64'(lat), 64'(elat));
        check($sformatf("result[%h]", op), 64'(result), 64'(er));
        check($sformatf("flags[%h]", op), 64'({overflow, invalid, inexact}), 64'({eo, ei, ex}));
        check($sformatf("in_ready_busy[%h]", op), 64'(in_ready), 64'd0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clock); #1;
            check($sformatf("hold_valid[%h]", op), 64'(out_valid), 64'd1);
            check($sformatf("hold_result[%h]", op), 64'(result), 64'(er));
        end
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock); #1;
        check($sformatf("release[%h]", op), 64'({out_valid, in_ready}), 64'b01);
    endtask

    initial begin
        int lat;
        nreset = 1'b0; in_valid = 1'b0; a = '0; out_ready = 1'b1;
        #12;
        check("reset_out", 64'({result, overflow, invalid, inexact, out_valid}), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clock); nreset = 1'b1;

        convert(16'h3F80, 0);
        convert(16'hC020, 0);
        convert(16'h3F00, 0);
        convert(16'h4EFF, 0);
        convert(16'h4F00, 0);
        convert(16'hCF00, 0);
        convert(16'h7FC1, 0);
        convert(16'hFF80, 0);
        convert(16'h0001, 0);

        // Backpressure with a competing operand held on the input throughout.
        @(negedge clock);
        a = 16'h4120; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clock); #1;
        a = 16'h3F80;
        wait_valid(lat);
        check("bp_latency", 64'(lat), 64'd6);
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            check("bp_hold", 64'({out_valid, in_ready, result}), {31'd0, 2'b10, 32'd10});
        end
        @(negedge clock); out_ready = 1'b1;
        @(posedge clock); #1;
        check("bp_release", 64'({out_valid, in_ready}), 64'b01);
        @(posedge clock); #1;
        in_valid = 1'b0;
        wait_valid(lat);
        check("bp_second_latency", 64'(lat), 64'd9);
        check("bp_second_result", 64'(result), 64'd1);

        // Reset in the middle of a long left shift.
        @(negedge clock);
        a = 16'h4EFF; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock); nreset = 1'b0;
        #1;
        check("midreset_out", 64'({result, overflow, invalid, inexact, out_valid}), 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clock); nreset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("midreset_quiet", 64'({out_valid, in_ready}), 64'b01);
        convert(16'h3F80, 0);

        for (int i = 0; i < 150; i++) begin
            logic [15:0] op;
            int sel;
            sel = int'($urandom_range(0, 9));
            op[15]  = 1'($urandom);
            op[6:0] = 7'($urandom);
            if (sel == 0)      op[14:7] = 8'hFF;
            else if (sel == 1) op[14:7] = 8'h00;
            else               op[14:7] = 8'($urandom_range(115, 162));
            convert(op, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
